// File: rtl/conv_pkg.sv
// Shared sizing helpers and FSM state constants for the convolution engine.
package conv_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_FETCH = 3'd1;
   localparam state_t ST_DRAIN = 3'd2;
   localparam state_t ST_BIAS  = 3'd3;
   localparam state_t ST_OUT   = 3'd4;

   function automatic int out_dim(input int in_sz, input int k, input int stride);
      return (in_sz - k) / stride + 1;
   endfunction

   // Never returns 0 so single-entry ranges still get a 1-bit port/counter.
   function automatic int clog2w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Unsigned pixel is widened by one bit before the signed multiply.
   function automatic int prod_w(input int dw, input int ww);
      return dw + ww + 1;
   endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate with bias add and optional ReLU on finalisation.
module conv_mac
   import conv_pkg::*;
#(
   parameter int DW    = 8,
   parameter int WW    = 8,
   parameter int ACC_W = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    clr,
   input  logic                    fin,
   input  logic                    relu_en,
   input  logic [DW-1:0]           pix,
   input  logic signed [WW-1:0]    wt,
   input  logic signed [ACC_W-1:0] bias,
   output logic signed [ACC_W-1:0] result
);

   localparam int PW = prod_w(DW, WW);

   logic signed [PW-1:0]    prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum;

   assign prod     = PW'($signed({1'b0, pix})) * PW'(wt);
   assign prod_ext = ACC_W'(prod);
   assign sum      = acc + bias;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         result <= '0;
      end else begin
         // clr marks the first tap of a window: load instead of accumulate.
         if (en) acc <= clr ? prod_ext : acc + prod_ext;
         if (fin) result <= (relu_en && sum[ACC_W-1]) ? '0 : sum;
      end
   end

endmodule

// File: rtl/conv_engine.sv
// Sequential convolution layer: walks oc/oy/ox windows, issues one tap address per
// cycle to sync-read memories, and streams bias+ReLU results over valid/ready.
module conv_engine
   import conv_pkg::*;
#(
   parameter int IN_H   = 16,
   parameter int IN_W   = 15,
   parameter int IN_CH  = 1,
   parameter int OUT_CH = 10,
   parameter int K_H    = 3,
   parameter int K_W    = 3,
   parameter int STRIDE = 1,
   parameter int DW     = 8,
   parameter int WW     = 8,
   parameter int ACC_W  = 24
) (
   input  logic                                                    clk,
   input  logic                                                    rst,
   input  logic                                                    start,
   input  logic                                                    relu_en,
   output logic                                                    busy,
   output logic [clog2w(IN_CH*IN_H*IN_W)-1:0]                      img_addr,
   input  logic [DW-1:0]                                           img_data,
   output logic [clog2w(OUT_CH*K_H*K_W*IN_CH)-1:0]                 w_addr,
   input  logic signed [WW-1:0]                                    w_data,
   output logic [clog2w(OUT_CH)-1:0]                               bias_addr,
   input  logic signed [ACC_W-1:0]                                 bias_data,
   output logic                                                    out_valid,
   input  logic                                                    out_ready,
   output logic signed [ACC_W-1:0]                                 out_pixel,
   output logic [clog2w(out_dim(IN_H,K_H,STRIDE)*out_dim(IN_W,K_W,STRIDE)*OUT_CH)-1:0] out_addr,
   output logic                                                    ch_done,
   output logic                                                    done
);

   localparam int OUT_H = out_dim(IN_H, K_H, STRIDE);
   localparam int OUT_W = out_dim(IN_W, K_W, STRIDE);
   localparam int NTAP  = K_H * K_W * IN_CH;
   localparam int NOUT  = OUT_H * OUT_W * OUT_CH;
   localparam int IA_W  = clog2w(IN_CH * IN_H * IN_W);
   localparam int WA_W  = clog2w(OUT_CH * NTAP);
   localparam int BA_W  = clog2w(OUT_CH);
   localparam int OA_W  = clog2w(NOUT);
   localparam int KX_W  = clog2w(K_W);
   localparam int KY_W  = clog2w(K_H);
   localparam int IC_W  = clog2w(IN_CH);
   localparam int OX_W  = clog2w(OUT_W);
   localparam int OY_W  = clog2w(OUT_H);
   localparam int OC_W  = clog2w(OUT_CH);

   state_t          state;
   logic [KX_W-1:0] kx;
   logic [KY_W-1:0] ky;
   logic [IC_W-1:0] ic;
   logic [OX_W-1:0] ox;
   logic [OY_W-1:0] oy;
   logic [OC_W-1:0] oc;
   logic            relu_q;
   logic            tap_vld;
   logic            tap_first;
   logic            fin;
   logic            kx_end, ky_end, ic_end;
   logic            ox_end, oy_end, oc_end;
   logic            hs;

   assign kx_end = (kx == KX_W'(K_W - 1));
   assign ky_end = (ky == KY_W'(K_H - 1));
   assign ic_end = (ic == IC_W'(IN_CH - 1));
   assign ox_end = (ox == OX_W'(OUT_W - 1));
   assign oy_end = (oy == OY_W'(OUT_H - 1));
   assign oc_end = (oc == OC_W'(OUT_CH - 1));
   assign hs     = (state == ST_OUT) && out_ready;
   assign fin    = (state == ST_BIAS);
   assign busy   = (state != ST_IDLE);

   // Addresses are pure functions of the counters, so they freeze whenever the counters do.
   assign img_addr  = IA_W'(ic) * IA_W'(IN_H * IN_W)
                    + (IA_W'(oy) * IA_W'(STRIDE) + IA_W'(ky)) * IA_W'(IN_W)
                    + IA_W'(ox) * IA_W'(STRIDE) + IA_W'(kx);
   assign w_addr    = WA_W'(oc) * WA_W'(NTAP)
                    + (WA_W'(ic) * WA_W'(K_H) + WA_W'(ky)) * WA_W'(K_W) + WA_W'(kx);
   assign bias_addr = BA_W'(oc);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         kx        <= '0;
         ky        <= '0;
         ic        <= '0;
         ox        <= '0;
         oy        <= '0;
         oc        <= '0;
         relu_q    <= 1'b0;
         tap_vld   <= 1'b0;
         tap_first <= 1'b0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         ch_done   <= 1'b0;
         done      <= 1'b0;
      end else begin
         tap_vld   <= 1'b0;
         tap_first <= 1'b0;
         ch_done   <= 1'b0;
         done      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  relu_q <= relu_en;
                  state  <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               // Data for this address lands next cycle; tag it for the MAC.
               tap_vld   <= 1'b1;
               tap_first <= (kx == '0) && (ky == '0) && (ic == '0);
               if (kx_end) begin
                  kx <= '0;
                  if (ky_end) begin
                     ky <= '0;
                     if (ic_end) begin
                        ic    <= '0;
                        state <= ST_DRAIN;
                     end else begin
                        ic <= ic + 1'b1;
                     end
                  end else begin
                     ky <= ky + 1'b1;
                  end
               end else begin
                  kx <= kx + 1'b1;
               end
            end
            ST_DRAIN: state <= ST_BIAS;
            ST_BIAS: begin
               out_valid <= 1'b1;
               state     <= ST_OUT;
            end
            ST_OUT: begin
               if (hs) begin
                  out_valid <= 1'b0;
                  ch_done   <= ox_end && oy_end;
                  done      <= ox_end && oy_end && oc_end;
                  out_addr  <= (ox_end && oy_end && oc_end) ? '0 : out_addr + 1'b1;
                  state     <= (ox_end && oy_end && oc_end) ? ST_IDLE : ST_FETCH;
                  if (ox_end) begin
                     ox <= '0;
                     if (oy_end) begin
                        oy <= '0;
                        oc <= oc_end ? '0 : oc + 1'b1;
                     end else begin
                        oy <= oy + 1'b1;
                     end
                  end else begin
                     ox <= ox + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   conv_mac #(
      .DW    (DW),
      .WW    (WW),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .en      (tap_vld),
      .clr     (tap_first),
      .fin     (fin),
      .relu_en (relu_q),
      .pix     (img_data),
      .wt      (w_data),
      .bias    (bias_data),
      .result  (out_pixel)
   );

endmodule

// File: tb/tb_conv_engine.sv
// Bench for conv_engine: a default-size instance (A) and a strided two-channel instance (B),
// both fed by sync-read memory models and checked against a direct convolution model.
module tb_conv_engine;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance A: defaults (16x15x1 -> 14x13x10, 3x3, stride 1)
   logic               start_a, relu_a, busy_a, out_valid_a, out_ready_a, ch_done_a, done_a;
   logic [7:0]         img_addr_a, img_data_a;
   logic [6:0]         w_addr_a;
   logic signed [7:0]  w_data_a;
   logic [3:0]         bias_addr_a;
   logic signed [23:0] bias_data_a, out_pixel_a;
   logic [10:0]        out_addr_a;

   // Instance B: 8x8x2 -> 3x3x2, 3x3, stride 2
   logic               start_b, relu_b, busy_b, out_valid_b, out_ready_b, ch_done_b, done_b;
   logic [6:0]         img_addr_b;
   logic [7:0]         img_data_b;
   logic [5:0]         w_addr_b;
   logic signed [7:0]  w_data_b;
   logic [0:0]         bias_addr_b;
   logic signed [23:0] bias_data_b, out_pixel_b;
   logic [4:0]         out_addr_b;

   int img_a [256];
   int w_a   [128];
   int bias_a[16];
   int img_b [128];
   int w_b   [64];
   int bias_b[2];

   conv_engine u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .relu_en(relu_a), .busy(busy_a),
      .img_addr(img_addr_a), .img_data(img_data_a), .w_addr(w_addr_a), .w_data(w_data_a),
      .bias_addr(bias_addr_a), .bias_data(bias_data_a), .out_valid(out_valid_a),
      .out_ready(out_ready_a), .out_pixel(out_pixel_a), .out_addr(out_addr_a),
      .ch_done(ch_done_a), .done(done_a)
   );

   conv_engine #(.IN_H(8), .IN_W(8), .IN_CH(2), .OUT_CH(2), .STRIDE(2)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .relu_en(relu_b), .busy(busy_b),
      .img_addr(img_addr_b), .img_data(img_data_b), .w_addr(w_addr_b), .w_data(w_data_b),
      .bias_addr(bias_addr_b), .bias_data(bias_data_b), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .out_pixel(out_pixel_b), .out_addr(out_addr_b),
      .ch_done(ch_done_b), .done(done_b)
   );

   always_ff @(posedge clk) begin
      img_data_a  <= 8'(img_a[img_addr_a]);
      w_data_a    <= 8'(w_a[w_addr_a]);
      bias_data_a <= 24'(bias_a[bias_addr_a]);
      img_data_b  <= 8'(img_b[img_addr_b]);
      w_data_b    <= 8'(w_b[w_addr_b]);
      bias_data_b <= 24'(bias_b[bias_addr_b]);
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Direct convolution from the layer definition.
   function automatic int model_a(input int oc, input int oy, input int ox, input bit relu);
      int s;
      s = bias_a[oc];
      for (int ky = 0; ky < 3; ky++)
         for (int kx = 0; kx < 3; kx++)
            s += img_a[(oy + ky) * 15 + ox + kx] * w_a[oc * 9 + ky * 3 + kx];
      if (relu && s < 0) s = 0;
      return s;
   endfunction

   function automatic int model_b(input int oc, input int oy, input int ox, input bit relu);
      int s;
      s = bias_b[oc];
      for (int ic = 0; ic < 2; ic++)
         for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
               s += img_b[ic * 64 + (oy * 2 + ky) * 8 + ox * 2 + kx] * w_b[oc * 18 + ic * 9 + ky * 3 + kx];
      if (relu && s < 0) s = 0;
      return s;
   endfunction

   task automatic fill_a(input int pv, input int wv, input int bv);
      for (int i = 0; i < 256; i++) img_a[i] = pv;
      for (int i = 0; i < 128; i++) w_a[i] = wv;
      for (int i = 0; i < 16; i++) bias_a[i] = bv;
   endtask

   task automatic fill_b(input int pv, input int wv, input int bv);
      for (int i = 0; i < 128; i++) img_b[i] = pv;
      for (int i = 0; i < 64; i++) w_b[i] = wv;
      for (int i = 0; i < 2; i++) bias_b[i] = bv;
   endtask

   task automatic reset_check(input string name);
      @(negedge clk);
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
      @(negedge clk);
      chk(name, int'(busy_a) + int'(out_valid_a) + int'(ch_done_a) + int'(done_a)
              + int'(img_addr_a) + int'(w_addr_a) + int'(bias_addr_a)
              + int'(out_pixel_a != 0) + int'(out_addr_a), 0);
      rst = 1'b0;
   endtask

   // Capture state for instance A
   int cap_a_addr[1820];
   int cap_a_pix [1820];
   int cap_a_n, chd_a_n, nd_a, chd_pos_bad, done_busy_bad, first_lat, done_cyc, stall_bad, stall_n;

   // mode 0: ready high; mode 1: random ready plus start/relu noise while busy;
   // mode 2: hold ready low for 5 cycles when pixel 3 is presented.
   task automatic run_a(input bit relu, input int mode, input int max_px);
      int cyc;
      bit fin;
      logic [23:0] hp;
      logic [10:0] ha;
      logic [7:0]  hi;
      cap_a_n = 0; chd_a_n = 0; nd_a = 0; chd_pos_bad = 0; done_busy_bad = 0;
      first_lat = -1; done_cyc = -1; stall_bad = 0; stall_n = 0;
      hp = '0; ha = '0; hi = '0;
      @(negedge clk);
      start_a = 1'b1; relu_a = relu; out_ready_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("busy after start", int'(busy_a), 1);
      cyc = 0; fin = 1'b0;
      while (!fin && cyc < 40000) begin
         if (mode == 1) begin
            start_a = busy_a ? 1'($urandom % 2) : 1'b0;
            relu_a  = busy_a ? 1'($urandom % 2) : relu;
            out_ready_a = 1'($urandom % 2);
         end else if (mode == 2 && out_valid_a && cap_a_n == 3 && stall_n < 5) begin
            if (stall_n == 0) begin
               hp = out_pixel_a; ha = out_addr_a; hi = img_addr_a;
            end else if (out_pixel_a !== hp || out_addr_a !== ha || img_addr_a !== hi) begin
               stall_bad++;
            end
            if (!out_valid_a) stall_bad++;
            out_ready_a = 1'b0;
            stall_n++;
         end else begin
            out_ready_a = 1'b1;
         end
         if (out_valid_a && first_lat < 0) first_lat = cyc;
         if (ch_done_a) begin
            chd_a_n++;
            if (cap_a_n == 0 || cap_a_n % 182 != 0) chd_pos_bad++;
         end
         if (done_a) begin
            nd_a++;
            done_cyc = cyc;
            if (busy_a) done_busy_bad++;
            fin = 1'b1;
         end
         if (out_valid_a && out_ready_a) begin
            if (cap_a_n < 1820) begin
               cap_a_addr[cap_a_n] = int'(out_addr_a);
               cap_a_pix[cap_a_n]  = int'($signed(out_pixel_a));
            end
            cap_a_n++;
            if (max_px < 1820 && cap_a_n >= max_px) fin = 1'b1;
         end
         if (!fin) begin
            @(negedge clk);
            cyc++;
         end
      end
      start_a = 1'b0; out_ready_a = 1'b1;
      if (!fin) chk("pass A completes within cycle budget", 0, 1);
   endtask

   task automatic check_a(input string tag, input bit relu, input int n);
      int bad_addr, bad_pix, e, lim;
      bad_addr = 0; bad_pix = 0;
      lim = (cap_a_n < n) ? cap_a_n : n;
      chk({tag, " output count"}, cap_a_n, n);
      for (int i = 0; i < lim; i++) begin
         if (cap_a_addr[i] != i) bad_addr++;
         e = model_a(i / 182, (i % 182) / 13, i % 13, relu);
         if (cap_a_pix[i] != e) begin
            if (bad_pix == 0) $display("  %s: pixel %0d got %0d want %0d", tag, i, cap_a_pix[i], e);
            bad_pix++;
         end
      end
      chk({tag, " out_addr order errors"}, bad_addr, 0);
      chk({tag, " pixel errors"}, bad_pix, 0);
   endtask

   // Capture state for instance B
   int cap_b_addr[18];
   int cap_b_pix [18];
   int cap_b_n, chd_b_n, nd_b, max_img_b;

   task automatic run_b(input bit relu);
      int c;
      cap_b_n = 0; chd_b_n = 0; nd_b = 0; max_img_b = 0;
      @(negedge clk);
      start_b = 1'b1; relu_b = relu;
      @(negedge clk);
      start_b = 1'b0; relu_b = 1'b0;
      c = 0;
      while (nd_b == 0 && c < 2000) begin
         if (busy_b && int'(img_addr_b) > max_img_b) max_img_b = int'(img_addr_b);
         if (out_valid_b) begin
            if (cap_b_n < 18) begin
               cap_b_addr[cap_b_n] = int'(out_addr_b);
               cap_b_pix[cap_b_n]  = int'($signed(out_pixel_b));
            end
            cap_b_n++;
         end
         if (ch_done_b) chd_b_n++;
         if (done_b) nd_b++;
         if (nd_b == 0) begin
            @(negedge clk);
            c++;
         end
      end
      if (nd_b == 0) chk("pass B completes within cycle budget", 0, 1);
   endtask

   typedef struct {
      int img;
      int wt;
      int bias;
      bit relu;
      int exp;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int bad, r;
      tbl[0] = '{1,   1,    0,   1'b0, 18};
      tbl[1] = '{10,  -1,   5,   1'b0, -175};
      tbl[2] = '{10,  -1,   5,   1'b1, 0};
      tbl[3] = '{255, 127,  3,   1'b0, 582933};
      tbl[4] = '{255, -128, -7,  1'b0, -587527};
      tbl[5] = '{3,   -2,   200, 1'b1, 92};

      rst = 1'b1; start_a = 1'b0; relu_a = 1'b0; out_ready_a = 1'b1;
      start_b = 1'b0; relu_b = 1'b0; out_ready_b = 1'b1;
      fill_a(0, 0, 0); fill_b(0, 0, 0);
      repeat (3) @(negedge clk);
      chk("reset state A", int'(busy_a) + int'(out_valid_a) + int'(ch_done_a) + int'(done_a)
                         + int'(img_addr_a) + int'(w_addr_a) + int'(bias_addr_a)
                         + int'(out_pixel_a != 0) + int'(out_addr_a), 0);
      chk("reset state B", int'(busy_b) + int'(out_valid_b) + int'(done_b) + int'(out_addr_b), 0);
      rst = 1'b0;

      // Full default pass, all ones
      fill_a(1, 1, 0);
      run_a(1'b0, 0, 1820);
      check_a("ones", 1'b0, 1820);
      chk("ones pixel 0 value", cap_a_pix[0], 9);
      chk("ones first valid latency", first_lat, 11);
      chk("ones done cycle (12 per pixel)", done_cyc, 1820 * 12);
      chk("ones ch_done count", chd_a_n, 10);
      chk("ones ch_done placement errors", chd_pos_bad, 0);
      chk("ones done count", nd_a, 1);
      chk("ones busy low with done", done_busy_bad, 0);

      // Negative sums with and without ReLU (first 20 pixels, then abort)
      fill_a(10, -1, 5);
      run_a(1'b0, 0, 20);
      check_a("neg", 1'b0, 20);
      chk("neg pixel 0 value", cap_a_pix[0], -85);
      reset_check("reset after neg pass");
      run_a(1'b1, 0, 20);
      check_a("relu", 1'b1, 20);
      chk("relu pixel 0 value", cap_a_pix[0], 0);
      reset_check("reset after relu pass");

      // Backpressure on pixel 3
      for (int i = 0; i < 256; i++) img_a[i] = int'($urandom_range(0, 255));
      for (int i = 0; i < 128; i++) w_a[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < 16; i++) bias_a[i] = int'($urandom_range(0, 20000)) - 10000;
      run_a(1'b0, 2, 10);
      check_a("stall", 1'b0, 10);
      chk("stall cycles held", stall_n, 5);
      chk("stall outputs/img_addr moved", stall_bad, 0);
      reset_check("reset after stall pass");

      // Reset while fetching pixel 50, then restart
      fill_a(1, 1, 0);
      run_a(1'b0, 0, 50);
      check_a("pre-abort", 1'b0, 50);
      @(negedge clk);
      @(negedge clk);
      chk("fetching pixel 50 before abort", int'(busy_a && !out_valid_a), 1);
      reset_check("reset mid-fetch");
      run_a(1'b0, 0, 1);
      chk("restart out_addr", cap_a_addr[0], 0);
      chk("restart pixel", cap_a_pix[0], 9);
      reset_check("reset after restart");

      // Random full pass with random backpressure and ignored start/relu noise
      for (int i = 0; i < 256; i++) img_a[i] = int'($urandom_range(0, 255));
      for (int i = 0; i < 128; i++) w_a[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < 16; i++) bias_a[i] = int'($urandom_range(0, 20000)) - 10000;
      r = int'($urandom % 2);
      run_a(1'(r), 1, 1820);
      check_a("random", 1'(r), 1820);
      chk("random ch_done count", chd_a_n, 10);
      chk("random ch_done placement errors", chd_pos_bad, 0);
      chk("random done count", nd_a, 1);
      chk("random busy low with done", done_busy_bad, 0);

      // Uniform-vector table on the strided two-channel instance
      for (int t = 0; t < 6; t++) begin
         fill_b(tbl[t].img, tbl[t].wt, tbl[t].bias);
         run_b(tbl[t].relu);
         bad = 0;
         for (int i = 0; i < 18; i++)
            if (cap_b_pix[i] != tbl[t].exp || cap_b_addr[i] != i) bad++;
         chk($sformatf("vec%0d pixel/addr errors", t), bad, 0);
         chk($sformatf("vec%0d output count", t), cap_b_n, 18);
         chk($sformatf("vec%0d ch_done count", t), chd_b_n, 2);
      end

      // Stride-2 ramp on channel 0 only
      fill_b(0, 1, 0);
      for (int rr = 0; rr < 8; rr++)
         for (int cc = 0; cc < 8; cc++) img_b[rr * 8 + cc] = rr * 8 + cc;
      run_b(1'b0);
      chk("ramp (0,0)", cap_b_pix[0], 81);
      chk("ramp (0,1)", cap_b_pix[1], 99);
      chk("ramp (1,0)", cap_b_pix[3], 225);
      bad = 0;
      for (int i = 0; i < 18; i++)
         if (cap_b_pix[i] != model_b(i / 9, (i % 9) / 3, i % 3, 1'b0)) bad++;
      chk("ramp pixel errors", bad, 0);

      // Two input planes with different values
      fill_b(1, 1, 0);
      for (int i = 64; i < 128; i++) img_b[i] = 2;
      run_b(1'b0);
      bad = 0;
      for (int i = 0; i < 18; i++) if (cap_b_pix[i] != 27) bad++;
      chk("two-plane pixel errors", bad, 0);
      chk("two-plane highest img_addr", max_img_b, 118);

      // Random data on instance B
      for (int i = 0; i < 128; i++) img_b[i] = int'($urandom_range(0, 255));
      for (int i = 0; i < 64; i++) w_b[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < 2; i++) bias_b[i] = int'($urandom_range(0, 40000)) - 20000;
      r = int'($urandom % 2);
      run_b(1'(r));
      bad = 0;
      for (int i = 0; i < 18; i++)
         if (cap_b_pix[i] != model_b(i / 9, (i % 9) / 3, i % 3, 1'(r)) || cap_b_addr[i] != i) bad++;
      chk("random B pixel/addr errors", bad, 0);
      chk("random B done count", nd_b, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/conv_engine.md
Name: conv_engine

Overview:
- Parametrised sequential convolution engine: next generation of the single-layer 3x3 conv block.
- Generalised in kernel size, stride, input/output channel count and data widths.
- Reads image, weights and bias from external synchronous-read memories, one multiply-accumulate (MAC) per cycle.
- Adds per-channel bias and optional ReLU; streams results over a valid/ready port to the layer buffer or the next layer.

Parameters:
IN_H, 16, input rows
IN_W, 15, input columns
IN_CH, 1, input channels
OUT_CH, 10, output channels (filters)
K_H, 3, kernel rows
K_W, 3, kernel columns
STRIDE, 1, window step in both dimensions
DW, 8, unsigned pixel width
WW, 8, signed weight width
ACC_W, 24, signed accumulator/output width; must be >= DW+WW+1+clog2(K_H*K_W*IN_CH)
Derived constants:
- OUT_H=(IN_H-K_H)/STRIDE+1, OUT_W=(IN_W-K_W)/STRIDE+1 (14x13 at defaults)
- NTAP=K_H*K_W*IN_CH
- NOUT=OUT_H*OUT_W*OUT_CH

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a layer pass; sampled only in IDLE
relu_en  in  1  latched at start; enables ReLU
busy  out  1  high from the cycle after start until the done pulse
img_addr  out  clog2(IN_CH*IN_H*IN_W)  image read address; data returns next cycle
img_data  in  DW  unsigned pixel
w_addr  out  clog2(OUT_CH*NTAP)  weight read address; data returns next cycle
w_data  in  WW  signed weight
bias_addr  out  clog2(OUT_CH)  bias read address (current output channel)
bias_data  in  ACC_W  signed bias; data returns next cycle
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_pixel  out  ACC_W  signed result
out_addr  out  clog2(NOUT)  oc*OUT_H*OUT_W + oy*OUT_W + ox
ch_done  out  1  one-cycle pulse on handshake of the last pixel of each output channel
done  out  1  one-cycle pulse on handshake of the last pixel of the layer

Behaviour:
- Reset values: all outputs 0, all counters 0, state IDLE.
  - rst mid-pass aborts immediately with no partial outputs; the next start restarts from out_addr 0.
- Iteration order: oc outer, then oy, then ox; taps ordered ic, ky, kx.
- Address formulas:
  - img_addr = ic*IN_H*IN_W + (oy*STRIDE+ky)*IN_W + ox*STRIDE+kx
  - w_addr = oc*NTAP + (ic*K_H+ky)*K_W + kx
  - bias_addr = oc
- States:
  - IDLE: start=1 -> FETCH (busy=1 next cycle); start is ignored in all other states.
  - FETCH: one tap address per cycle for NTAP cycles. The accumulator clears on the first data cycle. The last address -> DRAIN.
  - DRAIN: accumulates the final tap -> BIAS.
  - BIAS: out_pixel = acc + bias_data. If relu_en and the sum is negative, out_pixel = 0. Sets out_valid=1 -> OUT.
  - OUT: holds out_valid, out_pixel and out_addr stable until out_ready=1. On handshake:
    - if the pixel was last in its channel, ch_done=1;
    - if last overall, done=1 -> IDLE;
    - otherwise advance ox/oy/oc -> FETCH.
- Latency: first address issued the cycle after start; out_valid rises NTAP+2 cycles after the pixel's first address. Throughput is NTAP+3 cycles per pixel with out_ready tied high.
- Backpressure: no fetch while in OUT; an arbitrary out_ready stall loses or duplicates no outputs.
- Arithmetic:
  - pixel zero-extended to DW+1 signed; product DW+WW+1 bits, sign-extended to ACC_W.
  - wrap-around only on ACC_W overflow; legal ACC_W per the parameter rule never overflows.
- Boundary conditions:
  - out_ready high in the same cycle valid rises counts as a handshake in that cycle.
  - The final pixel raises ch_done and done together.
  - The done pulse is followed by busy=0 in the same cycle.

Decomposition:
- Shared package conv_pkg:
  - derived-size functions (out_dim(in,k,stride), clog2 wrapper);
  - state enum;
  - MAC product width constant.
- One sub-module: conv_mac. Signed MAC with clear/enable/accumulate and ReLU+bias finalisation. The engine top holds the FSM and address counters.

Test Plan:
1. Defaults, image all 1, weights all 1, bias 0, out_ready=1 -> 1820 outputs, each 9; out_addr 0..1819 in order; ch_done every 182 handshakes; single done at the end.
2. IN_H=IN_W=8, STRIDE=2, image[r][c]=r*8+c, weights 1, bias 0 -> 3x3 output; out_pixel(0,0)=81, out_pixel(0,1)=99, out_pixel(1,0)=225.
3. Image all 10, weights all -1, bias 5: relu_en=0 -> every out_pixel = -85; relu_en=1 -> every out_pixel = 0.
4. IN_CH=2, channel 0 pixels=1, channel 1 pixels=2, weights 1 -> every out_pixel = 27; img_addr covers both planes.
5. Backpressure: out_ready low 5 cycles on pixel 3 -> out_valid held, out_pixel/out_addr stable, img_addr frozen; next handshake gives addr 4.
6. start asserted while busy -> ignored. rst high during FETCH of pixel 50 -> all outputs 0 next cycle; restart yields out_addr 0 with correct value 9.
